mdu_iter: RTL and testbench

- Parametrised multiply/divide unit. Successor to the single-cycle combinational ALU; sits beside it in the EX stage.
- Executes MULT/MULTU/DIV/DIVU with a fixed, configurable multi-cycle latency and owns the HI/LO architectural registers.
- Exposes a busy flag so the hazard unit stalls MFHI/MFLO and new MDU ops until the result commits.

---
 rtl/mdu_iter_pkg.sv | 54 +++++
 rtl/mdu_iter_calc.sv | 86 ++++++++
 rtl/mdu_iter.sv | 135 +++++++++++++
 tb/tb_mdu_iter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit: op codes,
// FSM state encoding and op-classification helpers.
// Build option: MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops.
package mdu_defs;

  localparam logic [3:0] MDU_MULT  = 4'd0;
  localparam logic [3:0] MDU_MULTU = 4'd1;
  localparam logic [3:0] MDU_DIV   = 4'd2;
  localparam logic [3:0] MDU_DIVU  = 4'd3;
  localparam logic [3:0] MDU_MTHI  = 4'd4;
  localparam logic [3:0] MDU_MTLO  = 4'd5;
  localparam logic [3:0] MDU_MADD  = 4'd6;
  localparam logic [3:0] MDU_MADDU = 4'd7;
  localparam logic [3:0] MDU_MSUB  = 4'd8;
  localparam logic [3:0] MDU_MSUBU = 4'd9;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  // How the pending result is folded into HI/LO at commit time.
  typedef enum logic [1:0] {
    ACC_NONE = 2'd0,
    ACC_ADD  = 2'd1,
    ACC_SUB  = 2'd2
  } mdu_acc_e;

  // Ops that occupy the unit for a multi-cycle busy window.
  function automatic logic op_is_long(input logic [3:0] op);
    case (op)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: return 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Divides use the divide latency; every other long op uses the multiply latency.
  function automatic logic op_is_div(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  // Commit mode for a long op.
  function automatic mdu_acc_e op_acc_mode(input logic [3:0] op);
    case (op)
      MDU_MADD, MDU_MADDU: return ACC_ADD;
      MDU_MSUB, MDU_MSUBU: return ACC_SUB;
      default:             return ACC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mdu_iter_calc.sv
// mdu_calc: combinational arithmetic core. Maps (op, a, b) to the pending
// {ph, pl} pair, including the divide-by-zero and signed-overflow rules.
// Accumulate ops reuse the plain signed/unsigned product; the accumulation
// itself happens at commit time in mdu_iter.
module mdu_calc
  import mdu_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] ph,
  output logic [WIDTH-1:0] pl
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   den_s;
  logic [WIDTH-1:0]   den_u;
  logic [WIDTH-1:0]   sq_mag;
  logic [WIDTH-1:0]   sr_mag;
  logic [WIDTH-1:0]   uq;
  logic [WIDTH-1:0]   ur;

  // Products: signed via sign extension, unsigned via zero extension.
  assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  // Divide on magnitudes then restore signs; divisors are forced non-zero so
  // the divider never sees zero (the b==0 result is substituted below).
  always_comb begin
    a_neg  = a[WIDTH-1];
    b_neg  = b[WIDTH-1];
    a_mag  = a_neg ? -a : a;
    b_mag  = b_neg ? -b : b;
    den_s  = (b_mag == '0) ? ONE : b_mag;
    den_u  = (b == '0) ? ONE : b;
    sq_mag = a_mag / den_s;
    sr_mag = a_mag % den_s;
    uq     = a / den_u;
    ur     = a % den_u;
  end

  // Result select per op class.
  always_comb begin
    {ph, pl} = prod_s;
    case (op)
      MDU_MULTU, MDU_MADDU, MDU_MSUBU: begin
        {ph, pl} = prod_u;
      end
      MDU_DIV: begin
        if (b == '0) begin
          ph = a;
          pl = '1;
        end else if ((a == MIN_NEG) && (b == '1)) begin
          ph = '0;
          pl = a;
        end else begin
          ph = a_neg ? -sr_mag : sr_mag;
          pl = (a_neg ^ b_neg) ? -sq_mag : sq_mag;
        end
      end
      MDU_DIVU: begin
        if (b == '0) begin
          ph = a;
          pl = '1;
        end else begin
          ph = ur;
          pl = uq;
        end
      end
      default: begin
        {ph, pl} = prod_s;
      end
    endcase
  end

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: multi-cycle multiply/divide unit owning the HI/LO registers.
// Handshake: start is sampled only while busy=0; an op issued at edge E0
// holds busy high for exactly N cycles and HI/LO update in the cycle busy
// falls. start while busy, or with an undefined op code, is ignored.
// Build option: MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU (accumulate at commit).
module mdu_iter
  import mdu_defs::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] ph_q, ph_d;
  logic [WIDTH-1:0] pl_q, pl_d;
  logic [WIDTH-1:0] calc_ph;
  logic [WIDTH-1:0] calc_pl;
`ifdef MDU_MADD_EN
  mdu_acc_e         acc_q, acc_d;
`endif

  mdu_calc #(
    .WIDTH(WIDTH)
  ) u_calc (
    .op (op),
    .a  (a),
    .b  (b),
    .ph (calc_ph),
    .pl (calc_pl)
  );

  // Next-state: issue/move-to in IDLE, count down and commit in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    ph_d    = ph_q;
    pl_d    = pl_q;
`ifdef MDU_MADD_EN
    acc_d   = acc_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if (op_is_long(op)) begin
            state_d = RUN;
            cnt_d   = op_is_div(op) ? DIV_LOAD : MULT_LOAD;
            ph_d    = calc_ph;
            pl_d    = calc_pl;
`ifdef MDU_MADD_EN
            acc_d   = op_acc_mode(op);
`endif
          end else if (op == MDU_MTHI) begin
            hi_d = a;
          end else if (op == MDU_MTLO) begin
            lo_d = a;
          end
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
`ifdef MDU_MADD_EN
          case (acc_q)
            ACC_ADD: {hi_d, lo_d} = {hi_q, lo_q} + {ph_q, pl_q};
            ACC_SUB: {hi_d, lo_d} = {hi_q, lo_q} - {ph_q, pl_q};
            default: {hi_d, lo_d} = {ph_q, pl_q};
          endcase
`else
          {hi_d, lo_d} = {ph_q, pl_q};
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN);
  end

  // State registers; reset discards any in-flight op and clears HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      ph_q    <= '0;
      pl_q    <= '0;
`ifdef MDU_MADD_EN
      acc_q   <= ACC_NONE;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ph_q    <= ph_d;
      pl_q    <= pl_d;
`ifdef MDU_MADD_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Testbench for mdu_iter: directed scenarios plus randomized ops checked
// against a plain-arithmetic reference model of HI/LO.
module tb_mdu_iter;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic         clk;
  logic         reset;
  logic         start;
  logic [3:0]   op_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         busy;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_cmp;
  int n_fail;
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   hi_m;
  logic [W-1:0]   lo_m;

  mdu_iter #(
    .WIDTH(W),
    .MULT_CYCLES(MC),
    .DIV_CYCLES(DC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op_i),
    .a     (a_i),
    .b     (b_i),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the HI/LO pair an op should leave behind.
  function automatic logic [2*W-1:0] model(input logic [3:0] o, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
    longint sx, sy, q, r;
    logic [2*W-1:0] ux, uy, acc;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    ux  = {32'h0, x};
    uy  = {32'h0, y};
    acc = {hi_m, lo_m};
    case (o)
      4'd0: return sx * sy;
      4'd1: return ux * uy;
      4'd2: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, x};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      4'd3: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      4'd4: return {x, lo_m};
      4'd5: return {hi_m, x};
`ifdef MDU_MADD_EN
      4'd6: return acc + (sx * sy);
      4'd7: return acc + (ux * uy);
      4'd8: return acc - (sx * sy);
      4'd9: return acc - (ux * uy);
`endif
      default: return acc;
    endcase
  endfunction

  function automatic logic is_long(input logic [3:0] o);
`ifdef MDU_MADD_EN
    return (o <= 4'd3) || (o >= 4'd6 && o <= 4'd9);
`else
    return (o <= 4'd3);
`endif
  endfunction

  // Driver: issue a long op at the current negedge, measure busy window, check result.
  task automatic run_long(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int lat, input string name);
    logic [2*W-1:0] prev, expv;
    int cyc;
    exp_q.push_back(model(o, x, y));
    prev  = {hi, lo};
    start = 1'b1; op_i = o; a_i = x; b_i = y;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if ({hi, lo} !== prev) begin
      n_fail++;
      $display("FAIL %s early_commit: got %h want %h", name, {hi, lo}, prev);
    end
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    n_cmp++;
    if (cyc !== lat) begin
      n_fail++;
      $display("FAIL %s busy_cycles: got %0d want %0d", name, cyc, lat);
    end
    expv = exp_q.pop_front();
    n_cmp++;
    if ({hi, lo} !== expv) begin
      n_fail++;
      $display("FAIL %s hilo: got %h want %h", name, {hi, lo}, expv);
    end
    {hi_m, lo_m} = expv;
  endtask

  // Driver: issue a zero-latency or ignored op; busy must stay low.
  task automatic run_short(input logic [3:0] o, input logic [W-1:0] x, input string name);
    logic [2*W-1:0] expv;
    expv  = model(o, x, 32'h0);
    start = 1'b1; op_i = o; a_i = x; b_i = 32'h0;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || {hi, lo} !== expv) begin
      n_fail++;
      $display("FAIL %s short_op: busy=%b hilo=%h want busy=0 hilo=%h", name, busy, {hi, lo}, expv);
    end
    {hi_m, lo_m} = expv;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op_i = 4'd0; a_i = '0; b_i = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    hi_m = '0; lo_m = '0;
    n_cmp++;
    if (busy !== 1'b0 || hi !== '0 || lo !== '0) begin
      n_fail++;
      $display("FAIL reset: busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
    end
  endtask

  task automatic test_mult();
    run_long(4'd0, 32'hFFFF_FFFD, 32'd7, MC, "mult_neg");
    n_cmp++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
      n_fail++;
      $display("FAIL mult_const: got %h_%h want ffffffff_ffffffeb", hi, lo);
    end
    run_long(4'd1, 32'hFFFF_FFFF, 32'd2, MC, "multu");
    n_cmp++;
    if (hi !== 32'h1 || lo !== 32'hFFFF_FFFE) begin
      n_fail++;
      $display("FAIL multu_const: got %h_%h want 00000001_fffffffe", hi, lo);
    end
  endtask

  task automatic test_div();
    run_long(4'd2, 32'hFFFF_FFF9, 32'd2, DC, "div_neg");
    n_cmp++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      n_fail++;
      $display("FAIL div_const: got %h_%h want ffffffff_fffffffd", hi, lo);
    end
    run_long(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, DC, "div_ovf");
    n_cmp++;
    if (hi !== 32'h0 || lo !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL div_ovf_const: got %h_%h want 00000000_80000000", hi, lo);
    end
    run_long(4'd3, 32'h1234, 32'h0, DC, "divu_zero");
    n_cmp++;
    if (hi !== 32'h1234 || lo !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL divu_zero_const: got %h_%h want 00001234_ffffffff", hi, lo);
    end
    run_long(4'd2, 32'd55, 32'h0, DC, "div_zero");
  endtask

  // MULT in flight; DIV then MTHI attempted while busy must both be dropped.
  task automatic test_interlock();
    logic [2*W-1:0] expv;
    int cyc;
    expv  = model(4'd0, 32'd1000, 32'hFFFF_FFFE);
    start = 1'b1; op_i = 4'd0; a_i = 32'd1000; b_i = 32'hFFFF_FFFE;
    @(negedge clk);
    start = 1'b1; op_i = 4'd2; a_i = 32'd9; b_i = 32'd4;
    @(negedge clk);
    start = 1'b1; op_i = 4'd4; a_i = 32'hAA; b_i = 32'd0;
    @(negedge clk);
    start = 1'b0;
    cyc = 3;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    n_cmp++;
    if (cyc !== MC + 1) begin
      n_fail++;
      $display("FAIL interlock_busy: got %0d want %0d", cyc - 1, MC);
    end
    n_cmp++;
    if ({hi, lo} !== expv) begin
      n_fail++;
      $display("FAIL interlock_hilo: got %h want %h", {hi, lo}, expv);
    end
    repeat (DC + 2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || {hi, lo} !== expv) begin
      n_fail++;
      $display("FAIL interlock_late: busy=%b hilo=%h want 0 %h", busy, {hi, lo}, expv);
    end
    {hi_m, lo_m} = expv;
  endtask

  // Reset during a DIV, then MTLO from a clean state.
  task automatic test_reset_mid();
    logic saw;
    start = 1'b1; op_i = 4'd2; a_i = 32'd100; b_i = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    hi_m = '0; lo_m = '0;
    n_cmp++;
    if (busy !== 1'b0 || hi !== '0 || lo !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
    end
    saw = 1'b0;
    for (int i = 0; i < DC + 4; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || hi !== '0 || lo !== '0) saw = 1'b1;
    end
    n_cmp++;
    if (saw !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_commit: late activity seen=%b want 0", saw);
    end
    run_short(4'd5, 32'h55, "mtlo");
    n_cmp++;
    if (lo !== 32'h55 || hi !== 32'h0) begin
      n_fail++;
      $display("FAIL mtlo_const: got %h_%h want 00000000_00000055", hi, lo);
    end
  endtask

  // Random ops back to back, including undefined codes and edge operands.
  task automatic test_random();
    logic [3:0]   o;
    logic [W-1:0] x, y;
    int sel;
    for (int i = 0; i < 60; i++) begin
      o   = 4'($urandom_range(0, 15));
      x   = $urandom;
      y   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) y = 32'h0;
      if (sel == 1) begin
        x = 32'h8000_0000;
        y = 32'hFFFF_FFFF;
      end
      if (sel == 2) y = 32'($urandom_range(1, 9));
      if (is_long(o))
        run_long(o, x, y, (o == 4'd2 || o == 4'd3) ? DC : MC, "random_long");
      else
        run_short(o, x, "random_short");
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b1;
    start  = 1'b0;
    op_i   = '0;
    a_i    = '0;
    b_i    = '0;
    @(negedge clk);
    test_reset();
    test_mult();
    test_div();
    test_interlock();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
